mmio_bridge: RTL and testbench

- Multi-channel memory-mapped I/O bridge between the CPU's external data port (addr/re/we/wdata/rdata) and NUM_CH peripheral channels.
- Adds a ready handshake, per-access pipeline stall, timeout and error reporting, which a fixed-latency single external port cannot provide.
- Sits beside the internal DM. Only addresses at or above DM_LIMIT are serviced; lower addresses stay with the DM.

---
 rtl/mmio_pkg.sv | 19 +
 rtl/mmio_timeout_cnt.sv | 33 +++
 rtl/mmio_bridge.sv | 144 ++++++++++++++
 tb/tb_mmio_bridge.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_pkg.sv
// Shared definitions for the MMIO bridge: FSM states, address/data
// constants and the channel-index width helper.
package mmio_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [31:0] MMIO_DM_LIMIT      = 32'h0000_2000;
  localparam logic [31:0] MMIO_DEFAULT_RDATA = 32'h0000_DEAD;

  // Width of the channel-select field; a single channel still uses one bit.
  function automatic int unsigned ch_idx_w(input int unsigned num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

endpackage

// File: rtl/mmio_timeout_cnt.sv
// Saturating access-timeout counter with synchronous clear and enable.
module mmio_timeout_cnt #(
  parameter int unsigned LIMIT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned W = $clog2(LIMIT + 1);
  localparam logic [W-1:0] LAST = W'(LIMIT - 1);
  localparam logic [W-1:0] MAX  = W'(LIMIT);

  logic [W-1:0] cnt;

  // Count enabled cycles, holding at LIMIT until cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != MAX)) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Flags the cycle whose increment reaches LIMIT, so the owner can abort
  // in that same cycle rather than one cycle later.
  assign expired = (cnt == LAST);

endmodule

// File: rtl/mmio_bridge.sv
// Memory-mapped I/O bridge: turns the CPU's fixed-latency external data port
// into a ready-handshaked, timeout-protected access to one of NUM_CH channels.
module mmio_bridge
  import mmio_pkg::*;
#(
  parameter int unsigned         DATA_W        = 32,
  parameter int unsigned         ADDR_W        = 32,
  parameter int unsigned         NUM_CH        = 4,
  parameter int unsigned         CH_LSB        = 4,
  parameter logic [ADDR_W-1:0]   DM_LIMIT      = ADDR_W'(MMIO_DM_LIMIT),
  parameter int unsigned         TIMEOUT       = 15,
  parameter logic [DATA_W-1:0]   DEFAULT_RDATA = DATA_W'(MMIO_DEFAULT_RDATA)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [ADDR_W-1:0]        cpu_addr,
  input  logic                     cpu_re,
  input  logic                     cpu_we,
  input  logic [DATA_W-1:0]        cpu_wdata,
  output logic [DATA_W-1:0]        cpu_rdata,
  output logic                     cpu_stall,
  output logic                     err,
  output logic [NUM_CH-1:0]        ch_sel,
  output logic                     ch_re,
  output logic                     ch_we,
  output logic [ADDR_W-1:0]        ch_addr,
  output logic [DATA_W-1:0]        ch_wdata,
  input  logic [NUM_CH*DATA_W-1:0] ch_rdata,
  input  logic [NUM_CH-1:0]        ch_ready
);

  localparam int unsigned       IDXW     = ch_idx_w(NUM_CH);
  localparam logic [IDXW:0]     NUM_CH_L = (IDXW + 1)'(NUM_CH);

  state_t              state, state_next;
  logic                ext_req;
  logic [IDXW-1:0]     req_idx;
  logic                req_mapped;
  logic [NUM_CH-1:0]   req_onehot;
  logic                sel_ready;
  logic [DATA_W-1:0]   sel_rdata;
  logic                tmo_expired;

  // Decode the incoming request and its target channel.
  always_comb begin
    ext_req    = (cpu_re | cpu_we) && (cpu_addr >= DM_LIMIT);
    req_idx    = cpu_addr[CH_LSB +: IDXW];
    req_mapped = ({1'b0, req_idx} < NUM_CH_L);
    req_onehot = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      if (req_idx == IDXW'(k)) req_onehot[k] = 1'b1;
    end
  end

  // Pick the response of the selected channel only; others are ignored.
  always_comb begin
    sel_ready = |(ch_ready & ch_sel);
    sel_rdata = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      if (ch_sel[k]) sel_rdata |= ch_rdata[k*DATA_W +: DATA_W];
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state and stall decode.
  always_comb begin
    state_next = state;
    cpu_stall  = 1'b0;
    case (state)
      IDLE: begin
        cpu_stall = ext_req;
        if (ext_req) state_next = req_mapped ? REQ : DONE;
      end
      REQ: begin
        cpu_stall = 1'b1;
        if (sel_ready || tmo_expired) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Channel strobes, latched request, read-return data and sticky error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch_sel    <= '0;
      ch_re     <= 1'b0;
      ch_we     <= 1'b0;
      ch_addr   <= '0;
      ch_wdata  <= '0;
      cpu_rdata <= DEFAULT_RDATA;
      err       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (ext_req) begin
            ch_addr  <= cpu_addr;
            ch_wdata <= cpu_wdata;
            if (cpu_re && cpu_we) err <= 1'b1;
            if (req_mapped) begin
              ch_sel <= req_onehot;
              ch_we  <= cpu_we;
              ch_re  <= ~cpu_we;
            end else begin
              cpu_rdata <= DEFAULT_RDATA;
              err       <= 1'b1;
            end
          end
        end
        REQ: begin
          if (sel_ready) begin
            if (ch_re) cpu_rdata <= sel_rdata;
            ch_sel <= '0;
            ch_re  <= 1'b0;
            ch_we  <= 1'b0;
          end else if (tmo_expired) begin
            cpu_rdata <= DEFAULT_RDATA;
            err       <= 1'b1;
            ch_sel    <= '0;
            ch_re     <= 1'b0;
            ch_we     <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  mmio_timeout_cnt #(
    .LIMIT (TIMEOUT)
  ) u_tmo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (state != REQ),
    .en      (state == REQ),
    .expired (tmo_expired)
  );

endmodule

// File: tb/tb_mmio_bridge.sv
// Self-checking bench for mmio_bridge: directed scenarios plus randomized
// accesses checked against a transaction-level model of the bridge.
module tb_mmio_bridge;

  localparam int unsigned NCH = 4;
  localparam int unsigned DW  = 32;
  localparam int unsigned AW  = 32;
  localparam int unsigned TMO = 15;
  localparam logic [31:0] DEAD = 32'h0000_DEAD;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [AW-1:0]     cpu_addr = '0;
  logic              cpu_re = 1'b0;
  logic              cpu_we = 1'b0;
  logic [DW-1:0]     cpu_wdata = '0;
  logic [DW-1:0]     cpu_rdata;
  logic              cpu_stall;
  logic              err;
  logic [NCH-1:0]    ch_sel;
  logic              ch_re;
  logic              ch_we;
  logic [AW-1:0]     ch_addr;
  logic [DW-1:0]     ch_wdata;
  logic [NCH*DW-1:0] ch_rdata = '0;
  logic [NCH-1:0]    ch_ready = '0;

  // Three-channel instance for the unmapped-index case.
  logic [31:0] b_addr = '0;
  logic        b_re = 1'b0;
  logic        b_we = 1'b0;
  logic [31:0] b_wdata = '0;
  logic [31:0] b_rdata;
  logic        b_stall;
  logic        b_err;
  logic [2:0]  b_sel;
  logic        b_re_o;
  logic        b_we_o;
  logic [31:0] b_ch_addr;
  logic [31:0] b_ch_wdata;
  logic [95:0] b_ch_rdata = '0;
  logic [2:0]  b_ready = '0;

  mmio_bridge #(
    .DATA_W  (DW),
    .ADDR_W  (AW),
    .NUM_CH  (NCH),
    .CH_LSB  (4),
    .TIMEOUT (TMO)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cpu_addr  (cpu_addr),
    .cpu_re    (cpu_re),
    .cpu_we    (cpu_we),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_stall (cpu_stall),
    .err       (err),
    .ch_sel    (ch_sel),
    .ch_re     (ch_re),
    .ch_we     (ch_we),
    .ch_addr   (ch_addr),
    .ch_wdata  (ch_wdata),
    .ch_rdata  (ch_rdata),
    .ch_ready  (ch_ready)
  );

  mmio_bridge #(
    .NUM_CH (3)
  ) dut3 (
    .clk       (clk),
    .rst_n     (rst_n),
    .cpu_addr  (b_addr),
    .cpu_re    (b_re),
    .cpu_we    (b_we),
    .cpu_wdata (b_wdata),
    .cpu_rdata (b_rdata),
    .cpu_stall (b_stall),
    .err       (b_err),
    .ch_sel    (b_sel),
    .ch_re     (b_re_o),
    .ch_we     (b_we_o),
    .ch_addr   (b_ch_addr),
    .ch_wdata  (b_ch_wdata),
    .ch_rdata  (b_ch_rdata),
    .ch_ready  (b_ready)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] m_rdata;
  logic        m_err;
  logic [31:0] rdv [NCH];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One CPU access; lat = REQ cycle in which the target raises ready
  // (0 or beyond TIMEOUT means it never does).
  task automatic access(input logic [31:0] a, input logic r, input logic w,
                        input logic [31:0] d, input int unsigned lat);
    logic          ext, hit, done, active;
    logic [3:0]    exp_sel;
    logic [31:0]   rn;
    int unsigned   exp_str, stalls, rq;

    for (int k = 0; k < NCH; k++) begin
      rdv[k] = $urandom;
      ch_rdata[k*DW +: DW] = rdv[k];
    end
    ext     = (r | w) && (a >= 32'h0000_2000);
    hit     = (lat >= 1) && (lat <= TMO);
    exp_sel = 4'b0001 << a[5:4];
    exp_str = !ext ? 0 : (hit ? lat : TMO);
    if (ext) begin
      if (r && w) m_err = 1'b1;
      if (!hit) begin
        m_err   = 1'b1;
        m_rdata = DEAD;
      end else if (!w) begin
        m_rdata = rdv[a[5:4]];
      end
    end

    @(negedge clk);
    cpu_addr = a; cpu_re = r; cpu_we = w; cpu_wdata = d;
    stalls = 0; rq = 0; done = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      if (c > 0) @(negedge clk);
      active = ch_re | ch_we;
      if (active) begin
        rq++;
        if (rq == 1) begin
          chk("first_sel", ch_sel, exp_sel);
          chk("first_addr", ch_addr, a);
          chk("first_wdata", ch_wdata, d);
          chk("first_op", {ch_re, ch_we}, {~w, w});
        end
      end
      rn = $urandom;
      ch_ready = rn[3:0] & ~exp_sel;
      if (active && rq == lat) ch_ready = ch_ready | exp_sel;
      #1;
      if (cpu_stall) stalls++;
      else done = 1'b1;
    end
    chk("completed", done, 1'b1);
    chk("stall_cycles", stalls, ext ? exp_str + 1 : 0);
    chk("strobe_cycles", rq, exp_str);
    chk("rdata", cpu_rdata, m_rdata);
    chk("err", err, m_err);
    chk("done_idle", {ch_re, ch_we, ch_sel}, 6'd0);

    // Request stays asserted through DONE; it must not start a second access.
    @(negedge clk);
    cpu_re = 1'b0; cpu_we = 1'b0; ch_ready = '0;
    #1;
    chk("no_reissue", {ch_re, ch_we, cpu_stall}, 3'd0);
  endtask

  initial begin
    logic [31:0] a, d;
    logic        r, w;
    int unsigned op, lat, sel;

    // Reset values
    #12;
    chk("rst_rdata", cpu_rdata, DEAD);
    chk("rst_err", err, 1'b0);
    chk("rst_stall", cpu_stall, 1'b0);
    chk("rst_strobes", {ch_sel, ch_re, ch_we}, 6'd0);
    chk("rst_addr", ch_addr, 32'd0);
    chk("rst_wdata", ch_wdata, 32'd0);
    m_rdata = DEAD;
    m_err   = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Directed scenarios
    access(32'h0000_C010, 1'b1, 1'b0, 32'h0, 3);
    access(32'h0000_C000, 1'b0, 1'b1, 32'hA5A5_0001, 1);
    access(32'h0000_C020, 1'b1, 1'b0, 32'h0, 0);
    access(32'h0000_1FFC, 1'b1, 1'b0, 32'h0, 1);
    access(32'h0000_2000, 1'b1, 1'b0, 32'h0, 2);
    access(32'h0000_1FFF, 1'b0, 1'b1, 32'h1111_2222, 1);
    access(32'h0000_C030, 1'b1, 1'b0, 32'h0, TMO);
    access(32'h0000_C030, 1'b1, 1'b0, 32'h0, TMO + 1);
    access(32'h0000_C010, 1'b1, 1'b1, 32'h5555_AAAA, 2);

    // Unmapped channel index on the three-channel instance
    @(negedge clk);
    b_addr = 32'h0000_C030; b_re = 1'b1;
    #1;
    chk("unmap_stall", b_stall, 1'b1);
    chk("unmap_strobes_n", {b_sel, b_re_o, b_we_o}, 5'd0);
    @(negedge clk);
    #1;
    chk("unmap_done_stall", b_stall, 1'b0);
    chk("unmap_done_strobes", {b_sel, b_re_o, b_we_o}, 5'd0);
    chk("unmap_rdata", b_rdata, DEAD);
    chk("unmap_err", b_err, 1'b1);
    @(negedge clk);
    b_re = 1'b0;
    #1;
    chk("unmap_idle", {b_stall, b_sel, b_re_o, b_we_o}, 6'd0);

    // Randomized accesses
    for (int i = 0; i < 40; i++) begin
      sel = $urandom_range(0, 9);
      a   = (sel < 2) ? $urandom_range(0, 32'h1FFF) : $urandom_range(32'h2000, 32'hFFFF_FFFF);
      op  = $urandom_range(0, 7);
      r   = (op == 1) || (op >= 2 && op <= 4);
      w   = (op == 1) || (op >= 5);
      d   = $urandom;
      lat = $urandom_range(0, TMO + 2);
      access(a, r, w, d, lat);
    end

    // Asynchronous reset in the middle of an access
    @(negedge clk);
    cpu_addr = 32'h0000_C010; cpu_re = 1'b1; cpu_we = 1'b0; ch_ready = '0;
    @(negedge clk);
    #1;
    chk("mid_req_re", {ch_re, ch_sel}, 5'b1_0010);
    #1;
    rst_n = 1'b0; cpu_re = 1'b0;
    #1;
    chk("mid_rst_strobes", {ch_re, ch_we, ch_sel}, 6'd0);
    chk("mid_rst_rdata", cpu_rdata, DEAD);
    chk("mid_rst_err", err, 1'b0);
    chk("mid_rst_stall", cpu_stall, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    m_rdata = DEAD;
    m_err   = 1'b0;
    access(32'h0000_C010, 1'b1, 1'b0, 32'h0, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
